// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, status/ctrl bit positions and sequencer states for uart_ctrl
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_BUSY     = 5;

  localparam int CTRL_IE_RX = 0;
  localparam int CTRL_IE_TX = 1;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STROBE = 2'd1,
    TX_WAIT   = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  function automatic logic [31:0] status_word(
    input logic tx_full,
    input logic tx_empty,
    input logic rx_empty,
    input logic rx_full,
    input logic tx_ovf,
    input logic busy
  );
    logic [31:0] w;
    w              = '0;
    w[ST_TX_FULL]  = tx_full;
    w[ST_TX_EMPTY] = tx_empty;
    w[ST_RX_EMPTY] = rx_empty;
    w[ST_RX_FULL]  = rx_full;
    w[ST_TX_OVF]   = tx_ovf;
    w[ST_BUSY]     = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - byte FIFO with show-ahead head; push is accepted when full only alongside a pop
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  // a pop on an empty FIFO is a no-op, so there is never a bypass path
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - bus-facing controller that buffers bytes and sequences the uart we/re handshakes
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        uart_we,
  output logic [7:0]  uart_din,
  input  logic        uart_empty,
  output logic        uart_re,
  input  logic        uart_full,
  input  logic [7:0]  uart_dout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  logic          rd_req, wr_req;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]    tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;

  tx_state_e     tx_state_q, tx_state_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic          uart_we_q, uart_we_d;
  logic          uart_re_q, uart_re_d;
  logic [7:0]    uart_din_q, uart_din_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic [1:0]    ie_q, ie_d;
  logic          tx_ovf_q, tx_ovf_d;

  assign rd_req  = sel & ~wr;
  assign wr_req  = sel & wr;
  // bytes written while full are dropped here rather than relying on a same-cycle pop
  assign tx_push = wr_req & (addr == ADDR_DATA) & ~tx_full;
  assign rx_pop  = rd_req & (addr == ADDR_DATA);

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (uart_dout),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    uart_we_d  = 1'b0;
    uart_din_d = uart_din_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if ((tx_count != '0) && uart_empty) begin
          tx_pop     = 1'b1;
          uart_din_d = tx_head;
          uart_we_d  = 1'b1;
          tx_state_d = TX_STROBE;
        end
      end
      TX_STROBE: tx_state_d = TX_WAIT;
      // the transceiver drops empty one cycle after the strobe; wait for it before re-arming
      TX_WAIT: begin
        if (!uart_empty) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    uart_re_d  = 1'b0;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (uart_full && (rx_count != DEPTH_CNT)) begin
          rx_push    = 1'b1;
          uart_re_d  = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    ie_d     = ie_q;
    tx_ovf_d = tx_ovf_q;
    if (wr_req) begin
      case (addr)
        ADDR_DATA:   if (tx_full) tx_ovf_d = 1'b1;
        ADDR_STATUS: if (wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
        ADDR_CTRL:   ie_d = wdata[1:0];
        default:     ie_d = ie_q;
      endcase
    end
    if (rd_req) begin
      case (addr)
        ADDR_DATA:   rdata_d = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
        ADDR_STATUS: rdata_d = status_word(tx_full, tx_empty, rx_empty, rx_full,
                                           tx_ovf_q, ~uart_empty);
        ADDR_CTRL:   rdata_d = {30'd0, ie_q};
        default:     rdata_d = 32'd0;
      endcase
    end
    irq_d = (ie_q[CTRL_IE_RX] & ~rx_empty) |
            (ie_q[CTRL_IE_TX] & tx_empty & uart_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      uart_we_q  <= 1'b0;
      uart_re_q  <= 1'b0;
      uart_din_q <= 8'd0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
      ie_q       <= 2'd0;
      tx_ovf_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      uart_we_q  <= uart_we_d;
      uart_re_q  <= uart_re_d;
      uart_din_q <= uart_din_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      ie_q       <= ie_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign uart_we  = uart_we_q;
  assign uart_re  = uart_re_q;
  assign uart_din = uart_din_q;

endmodule
